// File: rtl/video_pattern_generator.sv
// Video test-pattern generator: passes upstream sync/enable through a
// two-stage pipeline and replaces the pixel colour with one of four patterns.
// Pattern selection, solid colour and moving-bar position are latched once
// per frame, at the falling edge of i_VSYNC.
//
// Ports:
//   i_CLK, i_RST_N                   pixel clock, async active-low reset
//   i_HSYNC, i_VSYNC, i_DE           upstream timing (syncs active-low)
//   i_X_COORD, i_Y_COORD             upstream pixel coordinates
//   i_MODE                           0 bars, 1 checker, 2 moving bar, 3 solid
//   i_SOLID_RGB                      {R,G,B} nibbles for mode 3
//   o_HSYNC, o_VSYNC, o_DE           timing delayed by two cycles
//   o_RED, o_GREEN, o_BLUE           pixel colour, aligned with o_DE
//   o_FRAME_START                    one-cycle pulse after each frame start
//   o_FRAME_COUNT                    frame starts since reset, mod 256
module video_pattern_generator #(
  parameter int unsigned p_H_ACTIVE  = 640,
  parameter int unsigned p_V_ACTIVE  = 480,
  parameter int unsigned p_CHECK_BIT = 5,
  parameter int unsigned p_BAR_WIDTH = 16,
  parameter int unsigned p_BAR_STEP  = 4
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_HSYNC,
  input  logic        i_VSYNC,
  input  logic        i_DE,
  input  logic [11:0] i_X_COORD,
  input  logic [11:0] i_Y_COORD,
  input  logic [1:0]  i_MODE,
  input  logic [11:0] i_SOLID_RGB,
  output logic        o_HSYNC,
  output logic        o_VSYNC,
  output logic        o_DE,
  output logic [3:0]  o_RED,
  output logic [3:0]  o_GREEN,
  output logic [3:0]  o_BLUE,
  output logic        o_FRAME_START,
  output logic [7:0]  o_FRAME_COUNT
);

  localparam int unsigned COORD_W = 12;
  localparam int unsigned CMP_W   = COORD_W + 1;
  localparam int unsigned RGB_W   = 12;

  // Per-frame state
  logic               prev_vsync;
  logic [1:0]         frame_mode;
  logic [RGB_W-1:0]   frame_solid;
  logic [COORD_W-1:0] bar_pos;

  // Stage 1: registered timing plus decoded pattern selectors
  logic               s1_hsync;
  logic               s1_vsync;
  logic               s1_de;
  logic [1:0]         s1_mode;
  logic [2:0]         s1_bar_k;
  logic               s1_check;
  logic               s1_in_bar;
  logic [RGB_W-1:0]   s1_solid;

  logic               frame_start_c;
  logic [COORD_W-1:0] bar_next_c;
  logic [CMP_W-1:0]   x_ext_c;
  logic [CMP_W-1:0]   pos_ext_c;
  logic [2:0]         bar_k_c;
  logic               in_bar_c;
  logic               check_c;
  logic [RGB_W-1:0]   rgb_c;
  logic               unused_bits_c;

  // Y only feeds the checkerboard bit; rows beyond the active area are
  // blanked by DE, so the remaining Y bits and the row count are not needed.
  assign unused_bits_c = ^{i_Y_COORD, 32'(p_V_ACTIVE)};

  assign frame_start_c = prev_vsync & ~i_VSYNC;
  assign x_ext_c       = {1'b0, i_X_COORD};
  assign pos_ext_c     = {1'b0, bar_pos};
  assign check_c       = i_X_COORD[p_CHECK_BIT] ^ i_Y_COORD[p_CHECK_BIT];

  // 13-bit compares so pos + width (or pos + step) cannot wrap
  assign in_bar_c   = (x_ext_c >= pos_ext_c) &&
                      (x_ext_c < (pos_ext_c + CMP_W'(p_BAR_WIDTH)));
  assign bar_next_c = ((pos_ext_c + CMP_W'(p_BAR_STEP)) >= CMP_W'(p_H_ACTIVE))
                      ? '0 : (bar_pos + COORD_W'(p_BAR_STEP));

  // Colour-bar index: number of eighth-width thresholds at or left of X
  always_comb begin
    bar_k_c = '0;
    for (int unsigned j = 1; j < 8; j++) begin
      if (x_ext_c >= CMP_W'((j * p_H_ACTIVE) / 8)) bar_k_c = bar_k_c + 3'd1;
    end
    if (x_ext_c >= CMP_W'(p_H_ACTIVE)) bar_k_c = 3'd7;
  end

  // Frame-start detection and per-frame latches
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      prev_vsync    <= 1'b1;
      o_FRAME_START <= 1'b0;
      o_FRAME_COUNT <= '0;
      frame_mode    <= '0;
      frame_solid   <= '0;
      bar_pos       <= '0;
    end else begin
      prev_vsync    <= i_VSYNC;
      o_FRAME_START <= frame_start_c;
      if (frame_start_c) begin
        o_FRAME_COUNT <= o_FRAME_COUNT + 8'd1;
        frame_mode    <= i_MODE;
        frame_solid   <= i_SOLID_RGB;
        bar_pos       <= bar_next_c;
      end
    end
  end

  // Stage 1 captures the frame state in effect before any same-edge update
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
      s1_de     <= 1'b0;
      s1_mode   <= '0;
      s1_bar_k  <= '0;
      s1_check  <= 1'b0;
      s1_in_bar <= 1'b0;
      s1_solid  <= '0;
    end else begin
      s1_hsync  <= i_HSYNC;
      s1_vsync  <= i_VSYNC;
      s1_de     <= i_DE;
      s1_mode   <= frame_mode;
      s1_bar_k  <= bar_k_c;
      s1_check  <= check_c;
      s1_in_bar <= in_bar_c;
      s1_solid  <= frame_solid;
    end
  end

  // Stage 2 colour selection; blank whenever DE is low
  always_comb begin
    rgb_c = '0;
    unique case (s1_mode)
      2'd0: begin
        unique case (s1_bar_k)
          3'd0: rgb_c = 12'hFFF;
          3'd1: rgb_c = 12'hFF0;
          3'd2: rgb_c = 12'h0FF;
          3'd3: rgb_c = 12'h0F0;
          3'd4: rgb_c = 12'hF0F;
          3'd5: rgb_c = 12'hF00;
          3'd6: rgb_c = 12'h00F;
          3'd7: rgb_c = 12'h000;
        endcase
      end
      2'd1: rgb_c = s1_check  ? 12'hFFF : 12'h000;
      2'd2: rgb_c = s1_in_bar ? 12'hFFF : 12'h00F;
      2'd3: rgb_c = s1_solid;
    endcase
    if (!s1_de) rgb_c = '0;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_HSYNC <= 1'b1;
      o_VSYNC <= 1'b1;
      o_DE    <= 1'b0;
      o_RED   <= '0;
      o_GREEN <= '0;
      o_BLUE  <= '0;
    end else begin
      o_HSYNC <= s1_hsync;
      o_VSYNC <= s1_vsync;
      o_DE    <= s1_de;
      o_RED   <= rgb_c[11:8];
      o_GREEN <= rgb_c[7:4];
      o_BLUE  <= rgb_c[3:0];
    end
  end

endmodule

// File: tb/tb_video_pattern_generator.sv
// Randomised scoreboard bench for video_pattern_generator. A frame-level
// reference model predicts timing/colour and frame-counter outputs; a
// separate monitor pops predictions when they fall due and compares.
module tb_video_pattern_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsync, vsync, de;
  logic [11:0] x_coord, y_coord;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;
  logic        o_hsync, o_vsync, o_de, o_frame_start;
  logic [3:0]  o_red, o_green, o_blue;
  logic [7:0]  o_frame_count;

  always #5 clk = ~clk;

  video_pattern_generator dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_HSYNC(hsync), .i_VSYNC(vsync),
    .i_DE(de), .i_X_COORD(x_coord), .i_Y_COORD(y_coord), .i_MODE(mode),
    .i_SOLID_RGB(solid_rgb), .o_HSYNC(o_hsync), .o_VSYNC(o_vsync),
    .o_DE(o_de), .o_RED(o_red), .o_GREEN(o_green), .o_BLUE(o_blue),
    .o_FRAME_START(o_frame_start), .o_FRAME_COUNT(o_frame_count)
  );

  typedef struct packed {
    logic        hs, vs, de;
    logic [11:0] rgb;
    logic [31:0] due;
  } pix_t;

  typedef struct packed {
    logic        fs;
    logic [7:0]  cnt;
    logic [31:0] due;
  } frm_t;

  pix_t pix_q[$];
  frm_t frm_q[$];

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] cyc = 0;
  logic        mon_en = 1'b0;
  logic        release_req = 1'b0;

  // Generator's own frame-level state
  int unsigned m_mode, m_pos, m_cnt;
  logic [11:0] m_solid;
  logic        m_prev;
  logic [11:0] pal [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h000};

  // Stimulus defaults used by the helper tasks
  logic        g_hs = 1'b1, g_vs = 1'b1;
  logic [1:0]  g_mode = 2'd1;
  logic [11:0] g_solid = 12'h000;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_cnt = 0; m_solid = 12'h000; m_prev = 1'b1;
  endtask

  function automatic logic [11:0] model_rgb(input int unsigned x,
                                            input int unsigned y,
                                            input logic pde);
    if (!pde) return 12'h000;
    case (m_mode)
      0: return pal[(x >= 640) ? 3'd7 : 3'((x * 8) / 640)];
      1: return ((((x / 32) ^ (y / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
      2: return (x >= m_pos && x < m_pos + 16) ? 12'hFFF : 12'h00F;
      default: return m_solid;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one pixel's worth of inputs and record what the DUT must produce
  task automatic drive(input logic phs, input logic pvs, input logic pde,
                       input int unsigned x, input int unsigned y,
                       input logic [1:0] pmode, input logic [11:0] psolid);
    pix_t p;
    frm_t f;
    @(negedge clk);
    if (release_req) begin
      rst_n = 1'b1;
      release_req = 1'b0;
      model_reset();
      mon_en = 1'b1;
    end
    hsync = phs; vsync = pvs; de = pde;
    x_coord = 12'(x); y_coord = 12'(y); mode = pmode; solid_rgb = psolid;
    p.hs = phs; p.vs = pvs; p.de = pde;
    p.rgb = model_rgb(x, y, pde);
    p.due = cyc + 32'd2;
    pix_q.push_back(p);
    f.fs = 1'b0;
    if (m_prev && !pvs) begin
      f.fs = 1'b1;
      m_cnt = (m_cnt + 1) % 256;
      m_mode = pmode;
      m_solid = psolid;
      m_pos = (m_pos + 4 >= 640) ? 0 : m_pos + 4;
    end
    f.cnt = 8'(m_cnt);
    f.due = cyc + 32'd1;
    frm_q.push_back(f);
    m_prev = pvs;
  endtask

  task automatic px(input logic pde, input int unsigned x, input int unsigned y);
    drive(g_hs, g_vs, pde, x, y, g_mode, g_solid);
  endtask

  // Vsync high for one line-ish, then the falling edge that starts a frame
  task automatic frame();
    g_vs = 1'b1; px(1'b0, 0, 0);
    g_vs = 1'b0; px(1'b0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " hsync"}, 32'(o_hsync), 32'd1);
    check({tag, " vsync"}, 32'(o_vsync), 32'd1);
    check({tag, " de"}, 32'(o_de), 32'd0);
    check({tag, " rgb"}, 32'({o_red, o_green, o_blue}), 32'd0);
    check({tag, " frame_start"}, 32'(o_frame_start), 32'd0);
    check({tag, " frame_count"}, 32'(o_frame_count), 32'd0);
  endtask

  // Monitor: compare each prediction on the cycle it falls due
  always @(negedge clk) begin
    if (mon_en) begin
      while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
        pix_t e;
        e = pix_q.pop_front();
        checks++;
        if (e.due != cyc ||
            {o_hsync, o_vsync, o_de, o_red, o_green, o_blue} !== {e.hs, e.vs, e.de, e.rgb}) begin
          errors++;
          $display("FAIL pixel @%0d: got hs=%b vs=%b de=%b rgb=%h expected hs=%b vs=%b de=%b rgb=%h (due %0d)",
                   cyc, o_hsync, o_vsync, o_de, {o_red, o_green, o_blue},
                   e.hs, e.vs, e.de, e.rgb, e.due);
        end
      end
      while (frm_q.size() > 0 && frm_q[0].due <= cyc) begin
        frm_t e;
        e = frm_q.pop_front();
        checks++;
        if (e.due != cyc || {o_frame_start, o_frame_count} !== {e.fs, e.cnt}) begin
          errors++;
          $display("FAIL frame @%0d: got start=%b count=%0d expected start=%b count=%0d",
                   cyc, o_frame_start, o_frame_count, e.fs, e.cnt);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    hsync = 1'b1; vsync = 1'b1; de = 1'b0;
    x_coord = '0; y_coord = '0; mode = 2'd1; solid_rgb = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    release_req = 1'b1;

    // Mode 0 after reset even though i_MODE=1; X=100 lands in bar 1
    repeat (3) px(1'b1, 100, 0);
    for (int i = 0; i < 40; i++)
      px(1'($urandom_range(0, 1)), $urandom_range(0, 700), $urandom_range(0, 479));
    for (int x = 0; x < 640; x += 80) begin px(1'b1, x, 0); px(1'b1, x + 79, 0); end

    // Solid A5C latched at frame start; mid-frame changes ignored
    g_mode = 2'd3; g_solid = 12'hA5C;
    frame();
    for (int i = 0; i < 10; i++) px(1'b1, $urandom_range(0, 639), $urandom_range(0, 479));
    g_solid = 12'h123; g_mode = 2'd0;
    for (int i = 0; i < 10; i++) px(1'($urandom_range(0, 1)), $urandom_range(0, 639), 0);

    // Checkerboard corners, blanking, random cells
    g_mode = 2'd1;
    frame();
    px(1'b1, 31, 0); px(1'b1, 32, 0); px(1'b1, 32, 32); px(1'b0, 32, 0);
    for (int i = 0; i < 30; i++)
      px(1'($urandom_range(0, 1)), $urandom_range(0, 639), $urandom_range(0, 479));
    g_mode = 2'd2;
    for (int i = 0; i < 10; i++) px(1'b1, $urandom_range(0, 639), $urandom_range(0, 479));

    // Moving bar through its wrap, sweeping the edges when it sits at 0
    for (int f = 0; f < 200; f++) begin
      frame();
      if (m_pos == 0) begin
        for (int x = 0; x <= 16; x++) px(1'b1, x, 0);
      end
      px(1'b1, m_pos, 0);
      px(1'b1, m_pos + 15, 0);
      px(1'b1, m_pos + 16, 0);
      px(1'b1, (m_pos > 0) ? m_pos - 1 : 639, 0);
    end

    // Frame counter wraps past 255; random solid each frame
    g_mode = 2'd3;
    for (int f = 0; f < 70; f++) begin
      g_solid = 12'($urandom);
      frame();
      px(1'b1, $urandom_range(0, 639), 0);
      g_mode = 2'($urandom);
    end

    // Fully random timing and controls
    for (int i = 0; i < 400; i++)
      drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 4095),
            $urandom_range(0, 4095), 2'($urandom), 12'($urandom));

    // Asynchronous reset in the middle of an active line
    g_hs = 1'b1; g_vs = 1'b0;
    for (int i = 0; i < 4; i++) px(1'b1, 200 + i, 0);
    mon_en = 1'b0;
    pix_q.delete();
    frm_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midline reset");
    repeat (2) @(negedge clk);
    release_req = 1'b1;
    g_mode = 2'd2;
    for (int i = 0; i < 6; i++) px(1'b1, 100, 0);
    for (int i = 0; i < 60; i++)
      drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 700),
            $urandom_range(0, 479), 2'($urandom), 12'($urandom));

    // Drain and confirm every prediction was consumed
    repeat (4) @(negedge clk);
    check("pixel queue drained", 32'(pix_q.size()), 32'd0);
    check("frame queue drained", 32'(frm_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
